cache_fill_fsm: RTL and testbench
=================================

# cache_fill_fsm

Miss-handling controller sitting directly beside the direct-mapped cache. When the cache's Miss output is raised, it fetches the 8-word (16-byte) block containing the missing address from main memory, writes each returned word into the cache data array, and then writes the tag/valid entry. It holds the pipeline stalled via `fsm_busy` for the whole fill.

## Interface
- No parameters. Block size is fixed at 8 words of 16 bits. Memory is byte-addressed with 2-byte words.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `miss_detected` input 1: cache Miss, qualified by the requester.
- `miss_address` input 16: byte address that missed.
- `memory_data_valid` input 1: memory returns one word this cycle.
- `memory_data` input 16: returned word. The top level wires it straight to the cache Data_In.
- `fsm_busy` output 1: fill in progress; stalls the requester.
- `memory_read` output 1: read request to memory, one word per cycle.
- `memory_address` output 16: byte address of the current read request.
- `cache_address` output 16: block base address presented to the cache during the fill.
- `write_data_array` output 1: cache Write_Data_Array.
- `word_num` output 3: cache Word_Num, the index of the word being written.
- `write_tag_array` output 1: cache Write_Tag_Array.

## Operation
- States: IDLE, FILL, TAG, held in a 2-bit register. Encoding 3 is illegal and recovers to IDLE.
- Registers:
  - `base[15:0]`
  - `issue_cnt[3:0]`, range 0..8
  - `rx_cnt[3:0]`, range 0..8
- IDLE:
  - All outputs are 0.
  - If `miss_detected` is 1: latch `base = {miss_address[15:4], 4'h0}`, clear both counters, go to FILL.
- FILL, request side:
  - `memory_read = (issue_cnt < 8)`.
  - `memory_address = base + {issue_cnt[2:0], 1'b0}`.
  - `issue_cnt` increments each cycle while it is below 8, then saturates at 8.
- FILL, response side:
  - `write_data_array = memory_data_valid & (rx_cnt < 8)`.
  - `word_num = rx_cnt[2:0]`.
  - `rx_cnt` increments on each accepted word.
  - When word 7 is accepted (`rx_cnt == 7` and valid), go to TAG.
- TAG:
  - `write_tag_array = 1` for exactly one cycle.
  - `word_num = 0`, `write_data_array = 0`, `memory_read = 0`.
  - Next state is IDLE.
- `cache_address = base` in FILL and TAG; 0 in IDLE.
- `fsm_busy = (state != IDLE)`. It is purely registered and has no combinational path from `miss_detected`.
- Address arithmetic is 16-bit. `base` is 16-byte aligned, so `base + 14` never carries past bit 3 and there is no wrap-around.
- The issue and response counters are independent. Any fixed memory latency of 1 or more cycles works, as does any response gap pattern.

## Timing
- Reset is asynchronous: while `rst` is 1, state is IDLE, `base`, `issue_cnt` and `rx_cnt` are 0, and every output is 0.
- Reset asserted mid-FILL or mid-TAG:
  - The fill is abandoned immediately.
  - No further writes occur, and the tag is not written.
  - Responses arriving after reset deasserts are ignored, because the FSM is in IDLE.
- Let E0 be the edge that samples `miss_detected` in IDLE. Then:
  - FILL is entered after E0.
  - `memory_read` is high for exactly 8 consecutive cycles starting the cycle after E0, with addresses base+0, +2, ..., +14 in order.
- With memory latency L cycles (valid L cycles after request), the last word is written in cycle 8+L-1 after E0. TAG follows in the next cycle, and IDLE (`fsm_busy` = 0) in the cycle after that.
- `miss_detected` is ignored while in FILL or TAG, including in the TAG cycle itself. A miss still present in the first IDLE cycle starts a new fill.
- `memory_data_valid` is ignored in IDLE, in TAG, and in FILL once `rx_cnt == 8` (not reachable in normal operation).
- A response arriving in the same cycle as a request is legal; both counters update on the same edge.
- A miss address change during FILL has no effect because `base` is latched.

## Test plan
- **Reset:** drive `rst` = 1 asynchronously mid-cycle.
  - Required: all outputs are 0 immediately.
  - Required: after release with `miss_detected` = 0, the block stays IDLE for 20 cycles.
- **Basic fill:** `miss_address` = 16'h3A57, memory latency 4.
  - Required: `memory_address` is 3A50, 3A52, ..., 3A5E on 8 consecutive cycles.
  - Required: `write_data_array` pulses with `word_num` 0..7, carrying data D0..D7.
  - Required: one `write_tag_array` pulse follows the last write.
  - Required: `cache_address` = 3A50 throughout, and `fsm_busy` is high for 8+4+1 = 13 cycles.
- **Gapped responses:** insert 2-cycle gaps between valids.
  - Required: `word_num` still advances 0..7 exactly once each.
  - Required: TAG occurs only after the 8th valid.
- **Back-to-back misses:** hold `miss_detected` high through an entire fill at 16'h00F0, then change the address to 16'hFFFE.
  - Required: the second fill starts one cycle after IDLE.
  - Required: its base is FFF0 and the last address is FFFE, with no overflow.
- **Reset mid-fill:** assert `rst` after 3 words have been written.
  - Required: no further `write_data_array` pulses and no `write_tag_array` pulse.
  - Required: the late memory valids after reset produce no writes.
- **Spurious valids:** pulse `memory_data_valid` while in IDLE and during TAG.
  - Required: no cache writes result, and the state is unchanged.

Source files
------------

// File: rtl/cache_fill_fsm.sv
// Miss-handling controller for the direct-mapped cache: fetches the 8-word block
// holding a missed address, writes each word into the data array, then the tag.
module cache_fill_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic        memory_data_valid,
  input  logic [15:0] memory_data,
  output logic        fsm_busy,
  output logic        memory_read,
  output logic [15:0] memory_address,
  output logic [15:0] cache_address,
  output logic        write_data_array,
  output logic [2:0]  word_num,
  output logic        write_tag_array
);

  localparam int unsigned AW         = 16;
  localparam int unsigned CW         = 4;
  localparam int unsigned BLK_WORDS  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    TAG  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   base_q, base_d;
  logic [CW-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;

  // The returned word goes straight to the cache data input; it is not consumed here.
  logic unused_memory_data;
  assign unused_memory_data = ^memory_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      issue_cnt_q <= '0;
      rx_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
    end
  end

  // Busy is a pure state decode, so the requester never sees a path from miss_detected.
  assign fsm_busy = (state_q != IDLE);

  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    issue_cnt_d      = issue_cnt_q;
    rx_cnt_d         = rx_cnt_q;
    memory_read      = 1'b0;
    memory_address   = '0;
    cache_address    = '0;
    write_data_array = 1'b0;
    word_num         = '0;
    write_tag_array  = 1'b0;

    case (state_q)
      IDLE: begin
        if (miss_detected) begin
          base_d      = {miss_address[AW-1:4], 4'h0};
          issue_cnt_d = '0;
          rx_cnt_d    = '0;
          state_d     = FILL;
        end
      end

      FILL: begin
        cache_address  = base_q;
        // Request and response counters run independently to tolerate any latency.
        memory_read    = (issue_cnt_q < CW'(BLK_WORDS));
        memory_address = base_q + AW'({issue_cnt_q[2:0], 1'b0});
        if (memory_read) begin
          issue_cnt_d = issue_cnt_q + CW'(1);
        end
        write_data_array = memory_data_valid && (rx_cnt_q < CW'(BLK_WORDS));
        word_num         = rx_cnt_q[2:0];
        if (write_data_array) begin
          rx_cnt_d = rx_cnt_q + CW'(1);
          if (rx_cnt_q == CW'(BLK_WORDS - 1)) begin
            state_d = TAG;
          end
        end
      end

      TAG: begin
        cache_address   = base_q;
        write_tag_array = 1'b1;
        state_d         = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm: reset, basic, gapped, back-to-back,
// reset-abort and spurious-valid scenarios with hand-computed expectations.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = 16'h0;
  logic        memory_data_valid = 1'b0;
  logic [15:0] memory_data = 16'h0;
  logic        fsm_busy;
  logic        memory_read;
  logic [15:0] memory_address;
  logic [15:0] cache_address;
  logic        write_data_array;
  logic [2:0]  word_num;
  logic        write_tag_array;

  int tests = 0;
  int fails = 0;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .fsm_busy          (fsm_busy),
    .memory_read       (memory_read),
    .memory_address    (memory_address),
    .cache_address     (cache_address),
    .write_data_array  (write_data_array),
    .word_num          (word_num),
    .write_tag_array   (write_tag_array)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string ctx);
    chk({ctx, " fsm_busy"}, 16'(fsm_busy), 16'h0);
    chk({ctx, " memory_read"}, 16'(memory_read), 16'h0);
    chk({ctx, " memory_address"}, memory_address, 16'h0);
    chk({ctx, " cache_address"}, cache_address, 16'h0);
    chk({ctx, " write_data_array"}, 16'(write_data_array), 16'h0);
    chk({ctx, " word_num"}, 16'(word_num), 16'h0);
    chk({ctx, " write_tag_array"}, 16'(write_tag_array), 16'h0);
  endtask

  // Drive this cycle's memory response, check outputs, advance to the next cycle.
  task automatic cyc(input logic v, input logic [15:0] d, input logic busy, input logic rd,
                     input logic [15:0] maddr, input logic [15:0] caddr, input logic wda,
                     input logic [2:0] wn, input logic wta);
    memory_data_valid = v;
    memory_data       = d;
    #1;
    chk("fsm_busy", 16'(fsm_busy), 16'(busy));
    chk("memory_read", 16'(memory_read), 16'(rd));
    if (rd || !busy) chk("memory_address", memory_address, maddr);
    chk("cache_address", cache_address, caddr);
    chk("write_data_array", 16'(write_data_array), 16'(wda));
    if (wda || wta || !busy) chk("word_num", 16'(word_num), 16'(wn));
    chk("write_tag_array", 16'(write_tag_array), 16'(wta));
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc(input logic v);
    cyc(v, 16'hBEEF, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 1'b0);
  endtask

  initial begin
    int k;
    logic v;

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #1 chk_zero("async_reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) idle_cyc(1'b0);

    // Basic fill, latency 4.
    miss_detected = 1'b1;
    miss_address  = 16'h3A57;
    idle_cyc(1'b0);
    miss_detected = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      v = (c >= 4) && (c <= 11);
      cyc(v, 16'(32'hD000 + c - 4), 1'b1, c < 8, 16'(32'h3A50 + 2 * c), 16'h3A50,
          v, 3'(c - 4), c == 12);
    end
    idle_cyc(1'b0);

    // Gapped responses; a valid during TAG and in IDLE must not write.
    miss_detected = 1'b1;
    miss_address  = 16'h1238;
    idle_cyc(1'b0);
    miss_detected = 1'b0;
    k = 0;
    for (int c = 0; c <= 24; c++) begin
      v = (c >= 2) && (c <= 23) && ((c - 2) % 3 == 0);
      if (c == 24) begin
        cyc(1'b1, 16'h5555, 1'b1, 1'b0, 16'h0, 16'h1230, 1'b0, 3'd0, 1'b1);
      end else begin
        cyc(v, 16'(32'hA000 + k), 1'b1, c < 8, 16'(32'h1230 + 2 * c), 16'h1230,
            v, 3'(k), 1'b0);
      end
      if (v) k++;
    end
    idle_cyc(1'b1);
    idle_cyc(1'b1);

    // Back-to-back misses: held miss is ignored in TAG, retaken in first IDLE cycle.
    miss_detected = 1'b1;
    miss_address  = 16'h00F0;
    idle_cyc(1'b0);
    for (int c = 0; c <= 9; c++) begin
      v = (c >= 1) && (c <= 8);
      if (c == 9) miss_address = 16'hFFFE;
      cyc(v, 16'(32'hC000 + c), 1'b1, c < 8, 16'(32'h00F0 + 2 * c), 16'h00F0,
          v, 3'(c - 1), c == 9);
    end
    idle_cyc(1'b0);
    miss_detected = 1'b0;
    for (int c = 0; c <= 9; c++) begin
      v = (c >= 1) && (c <= 8);
      cyc(v, 16'(32'hE000 + c), 1'b1, c < 8, 16'(32'hFFF0 + 2 * c), 16'hFFF0,
          v, 3'(c - 1), c == 9);
    end
    idle_cyc(1'b0);

    // Reset mid-fill after three words, late valids must be ignored.
    miss_detected = 1'b1;
    miss_address  = 16'h5A5A;
    idle_cyc(1'b0);
    miss_detected = 1'b0;
    for (int c = 0; c <= 4; c++) begin
      v = (c >= 2);
      cyc(v, 16'(32'hF000 + c), 1'b1, 1'b1, 16'(32'h5A50 + 2 * c), 16'h5A50,
          v, 3'(c - 2), 1'b0);
    end
    memory_data_valid = 1'b1;
    rst = 1'b1;
    #1 chk_zero("reset_mid_fill");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) idle_cyc(1'b1);
    idle_cyc(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
